// File: rtl/sprite_fetch_sched_pkg.sv
// sprite_fetch_sched_pkg: shared config encodings, ctrl bit positions and sprite entry type
package sprite_fetch_sched_pkg;
  localparam logic [1:0] CFG_X    = 2'd0;
  localparam logic [1:0] CFG_Y    = 2'd1;
  localparam logic [1:0] CFG_TILE = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_HFLIP = 1;
  localparam logic [23:0] TRANSPARENT = 24'h000000;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] tile;
    logic       en;
    logic       hflip;
  } sprite_t;
endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test: combinational window compare for one sprite slot
// Ports: spr (active entry), hcount/vcount (pixel position) -> hit, lx/ly (offset inside sprite).
// With SPRITE_HFLIP_EN defined, lx is mirrored when the entry's hflip bit is set.
module sprite_hit_test
  import sprite_fetch_sched_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  sprite_t                    spr,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  output logic                       hit,
  output logic [$clog2(SPR_W)-1:0]   lx,
  output logic [$clog2(SPR_H)-1:0]   ly
);
  logic [10:0] dx, dy;
  // 11-bit differences: a sprite near column 1023 never wraps onto column 0
  always_comb begin
    dx  = {1'b0, hcount} - {1'b0, spr.x};
    dy  = {1'b0, vcount} - {1'b0, spr.y};
    hit = spr.en && hcount >= spr.x && vcount >= spr.y && dx < 11'(SPR_W) && dy < 11'(SPR_H);
`ifdef SPRITE_HFLIP_EN
    lx  = spr.hflip ? ~dx[$clog2(SPR_W)-1:0] : dx[$clog2(SPR_W)-1:0];
`else
    lx  = dx[$clog2(SPR_W)-1:0];
`endif
    ly  = dy[$clog2(SPR_H)-1:0];
  end
`ifndef SPRITE_HFLIP_EN
  logic unused_hflip;
  assign unused_hflip = spr.hflip;
`endif
endmodule

// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched: per-pixel sprite hit test and shared sprite ROM fetch scheduler
// Ports: cfg_we/cfg_idx/cfg_sel/cfg_data write shadow sprite registers; hcount/vcount/bright_in
// are the raster inputs; rom_addr/rom_data talk to the shared sync ROM; pixel/pix_en and the
// delayed bright_out/hcount_out/vcount_out reach the colour stage aligned, L = 2 + ROM_LAT.
// Optional macro SPRITE_HFLIP_EN enables ctrl bit1 horizontal flip.
module sprite_fetch_sched
  import sprite_fetch_sched_pkg::*;
#(
  parameter int NUM_SPR    = 4,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 24,
  parameter int ROM_LAT    = 1,
  parameter int V_COMMIT   = 481
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_SPR)-1:0] cfg_idx,
  input  logic [1:0]                 cfg_sel,
  input  logic [9:0]                 cfg_data,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  input  logic                       bright_in,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic [DATA_WIDTH-1:0]      pixel,
  output logic                       pix_en,
  output logic                       bright_out,
  output logic [9:0]                 hcount_out,
  output logic [9:0]                 vcount_out
);
  localparam int LX_W = $clog2(SPR_W);
  localparam int LY_W = $clog2(SPR_H);
  localparam int L    = ROM_LAT + 2;
  sprite_t            shadow [NUM_SPR];
  sprite_t            active [NUM_SPR];
  logic [NUM_SPR-1:0] hit;
  logic [LX_W-1:0]    lx [NUM_SPR];
  logic [LY_W-1:0]    ly [NUM_SPR];
  logic               any;
  logic [LX_W-1:0]    win_lx;
  logic [LY_W-1:0]    win_ly;
  logic [9:0]         win_tile;
  logic               commit;
  logic [ROM_LAT:0]   vp;
  logic [9:0]         hd [L];
  logic [9:0]         vd [L];
  logic [L-1:0]       bd;
  assign commit = hcount == 10'd0 && vcount == 10'(V_COMMIT);
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_hit
    sprite_hit_test #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .spr(active[i]), .hcount(hcount), .vcount(vcount),
      .hit(hit[i]), .lx(lx[i]), .ly(ly[i])
    );
  end
  // descending scan so the lowest-index hit wins
  always_comb begin
    any      = 1'b0;
    win_lx   = '0;
    win_ly   = '0;
    win_tile = '0;
    for (int k = NUM_SPR - 1; k >= 0; k--)
      if (hit[k]) begin
        any      = 1'b1;
        win_lx   = lx[k];
        win_ly   = ly[k];
        win_tile = active[k].tile;
      end
  end
  // active copies the pre-write shadow, so a write in the commit cycle waits a frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NUM_SPR; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (commit)
        for (int k = 0; k < NUM_SPR; k++) active[k] <= shadow[k];
      if (cfg_we)
        case (cfg_sel)
          CFG_X:    shadow[cfg_idx].x    <= cfg_data;
          CFG_Y:    shadow[cfg_idx].y    <= cfg_data;
          CFG_TILE: shadow[cfg_idx].tile <= cfg_data;
          default: begin
            shadow[cfg_idx].en    <= cfg_data[CTRL_EN];
`ifdef SPRITE_HFLIP_EN
            shadow[cfg_idx].hflip <= cfg_data[CTRL_HFLIP];
`else
            shadow[cfg_idx].hflip <= 1'b0;
`endif
          end
        endcase
    end
  // with power-of-2 sizes the concatenation equals tile*W*H + ly*W + lx
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rom_addr <= '0;
      vp       <= '0;
      pix_en   <= 1'b0;
      pixel    <= '0;
      bd       <= '0;
      for (int k = 0; k < L; k++) begin
        hd[k] <= '0;
        vd[k] <= '0;
      end
    end else begin
      rom_addr <= any ? ADDR_WIDTH'({win_tile, win_ly, win_lx}) : rom_addr;
      vp       <= {vp[ROM_LAT-1:0], any & bright_in};
      pix_en   <= vp[ROM_LAT];
      pixel    <= vp[ROM_LAT] ? rom_data : '0;
      bd       <= {bd[L-2:0], bright_in};
      hd[0]    <= hcount;
      vd[0]    <= vcount;
      for (int k = 1; k < L; k++) begin
        hd[k] <= hd[k-1];
        vd[k] <= vd[k-1];
      end
    end
  assign bright_out = bd[L-1];
  assign hcount_out = hd[L-1];
  assign vcount_out = vd[L-1];
endmodule

// File: tb/tb_sprite_fetch_sched.sv
// tb_sprite_fetch_sched: scoreboard bench with a behavioural sprite model and sync ROM model
module tb_sprite_fetch_sched;
  localparam int L = 3;
`ifdef SPRITE_HFLIP_EN
  localparam bit HF = 1'b1;
`else
  localparam bit HF = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0, cfg_we = 1'b0, bright_in = 1'b0;
  logic [1:0]  cfg_idx = '0, cfg_sel = '0;
  logic [9:0]  cfg_data = '0, hcount = '0, vcount = '0;
  logic [13:0] rom_addr;
  logic [23:0] rom_data, pixel;
  logic        pix_en, bright_out;
  logic [9:0]  hcount_out, vcount_out;

  sprite_fetch_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .hcount(hcount), .vcount(vcount), .bright_in(bright_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel), .pix_en(pix_en),
    .bright_out(bright_out), .hcount_out(hcount_out), .vcount_out(vcount_out)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [13:0] a);
    return 24'({10'd0, a} * 24'd40503) ^ 24'hA5C3E1;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int k; bit pe; logic [23:0] px; bit br; int h; int v;} out_t;
  typedef struct {int k; int a;} addr_t;
  out_t  oq[$];
  addr_t aq[$];
  int tests = 0, fails = 0;

  int sx[4], sy[4], st[4], ax[4], ay[4], at[4];
  bit sen[4], sfl[4], aen[4], afl[4];
  int last_addr = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  task automatic step(input int h, input int v, input bit br,
                      input bit we = 0, input int idx = 0, input int sel = 0, input int data = 0);
    out_t o;
    addr_t ad;
    int w, lx, ly;
    hcount = 10'(h); vcount = 10'(v); bright_in = br;
    cfg_we = we; cfg_idx = 2'(idx); cfg_sel = 2'(sel); cfg_data = 10'(data);
    w = -1;
    for (int i = 3; i >= 0; i--)
      if (aen[i] && h >= ax[i] && h < ax[i] + 16 && v >= ay[i] && v < ay[i] + 16) w = i;
    if (w >= 0) begin
      lx = h - ax[w];
      ly = v - ay[w];
      if (HF && afl[w]) lx = 15 - lx;
      last_addr = (at[w] * 256 + ly * 16 + lx) % 16384;
    end
    o.k = cyc + 1; o.pe = (w >= 0) && br;
    o.px = o.pe ? rom_f(14'(last_addr)) : 24'h0;
    o.br = br; o.h = h; o.v = v;
    oq.push_back(o);
    ad.k = cyc + 1; ad.a = last_addr;
    aq.push_back(ad);
    if (h == 0 && v == 481)
      for (int i = 0; i < 4; i++) begin
        ax[i] = sx[i]; ay[i] = sy[i]; at[i] = st[i]; aen[i] = sen[i]; afl[i] = sfl[i];
      end
    if (we)
      case (sel)
        0: sx[idx] = data;
        1: sy[idx] = data;
        2: st[idx] = data;
        default: begin sen[idx] = data[0]; sfl[idx] = HF & data[1]; end
      endcase
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    oq.delete();
    aq.delete();
    #1;
    chk("rst_pix_en", pix_en, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_bright_out", bright_out, 0);
    chk("rst_hcount_out", hcount_out, 0);
    chk("rst_vcount_out", vcount_out, 0);
    for (int i = 0; i < 4; i++) begin
      sx[i] = 0; sy[i] = 0; st[i] = 0; sen[i] = 0; sfl[i] = 0;
      ax[i] = 0; ay[i] = 0; at[i] = 0; aen[i] = 0; afl[i] = 0;
    end
    last_addr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].k <= cyc) begin
      if (aq[0].k == cyc) chk("rom_addr", rom_addr, aq[0].a);
      else chk("rom_addr_missed", aq[0].k, cyc);
      aq.delete(0);
    end
    while (oq.size() > 0 && oq[0].k + L - 1 <= cyc) begin
      if (oq[0].k + L - 1 == cyc) begin
        chk("pix_en", pix_en, oq[0].pe);
        chk("pixel", pixel, oq[0].px);
        chk("bright_out", bright_out, oq[0].br);
        chk("hcount_out", hcount_out, oq[0].h);
        chk("vcount_out", vcount_out, oq[0].v);
      end else chk("out_missed", oq[0].k, cyc);
      oq.delete(0);
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    repeat (40) step($urandom_range(0, 639), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
    step(0, 481, 1);
    repeat (20) step($urandom_range(0, 639), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
    step(5, 5, 1, 1, 0, 0, 100); step(5, 5, 1, 1, 0, 1, 50);
    step(5, 5, 1, 1, 0, 2, 2);   step(5, 5, 1, 1, 0, 3, 1);
    step(6, 5, 1, 1, 1, 0, 200); step(6, 5, 1, 1, 1, 1, 200);
    step(6, 5, 1, 1, 1, 2, 1);   step(6, 5, 1, 1, 1, 3, 1);
    step(7, 5, 1, 1, 3, 0, 200); step(7, 5, 1, 1, 3, 1, 200);
    step(7, 5, 1, 1, 3, 2, 3);   step(7, 5, 1, 1, 3, 3, 1);
    step(105, 53, 1);
    step(0, 481, 1);
    step(105, 53, 1);
    for (int h = 95; h <= 120; h++) step(h, 53, 1);
    for (int h = 195; h <= 218; h++) step(h, 205, 1);
    for (int v = 196; v <= 218; v++) step(203, v, 1'(v % 2));
    step(8, 8, 1, 1, 1, 3, 0);
    step(203, 205, 1);
    step(0, 481, 1);
    step(203, 205, 1); step(215, 215, 1);
    step(20, 20, 1, 1, 0, 0, 300);
    step(105, 53, 1); step(305, 53, 1);
    step(0, 481, 1);
    step(105, 53, 1); step(305, 53, 1);
    step(0, 481, 1, 1, 0, 0, 400);
    step(305, 53, 1); step(405, 53, 1);
    step(0, 481, 1);
    step(405, 53, 1); step(305, 53, 1);
    step(1, 1, 1, 1, 2, 0, 630); step(1, 1, 1, 1, 2, 1, 10);
    step(1, 1, 1, 1, 2, 2, 5);   step(1, 1, 1, 1, 2, 3, 3);
    step(0, 481, 1);
    for (int h = 625; h <= 639; h++) step(h, 12, h != 634);
    for (int h = 0; h <= 3; h++) step(h, 12, 1);
    step(2, 2, 1, 1, 0, 0, 100); step(2, 2, 1, 1, 0, 3, 3);
    step(0, 481, 1);
    step(100, 53, 1); step(101, 53, 1); step(115, 60, 1); step(116, 60, 1);
    step(632, 12, 1); step(633, 12, 1);
    do_reset();
    repeat (6) step(632, 12, 1);
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) step(0, 481, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) begin
        int sel;
        sel = $urandom_range(0, 3);
        step($urandom_range(0, 79), $urandom_range(0, 79), 1'($urandom_range(0, 1)), 1,
             $urandom_range(0, 3), sel,
             sel < 2 ? $urandom_range(0, 63) : sel == 2 ? $urandom_range(0, 1023) : $urandom_range(0, 3));
      end else step($urandom_range(0, 79), $urandom_range(0, 79), 1'($urandom_range(0, 3) != 0));
    end
    repeat (L + 2) @(negedge clk);
    chk("drain", oq.size() + aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
